// File: rtl/trig_event_capture_pkg.sv
// Shared constants and helpers for the event-to-trigger capture block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package trig_event_pkg;

    localparam int N_DEF      = 16;
    localparam int HOLD_W_DEF = 8;
    localparam int MISS_W_DEF = 16;

    // Saturation value of the missed-event counter.
    localparam logic [MISS_W_DEF-1:0] MISS_MAX = '1;

    // Width needed to hold a count of 0..N_DEF set bits.
    localparam int CNT_W = $clog2(N_DEF + 1);

    // Number of set bits in an N_DEF-wide vector.
    function automatic logic [CNT_W-1:0] popcount(input logic [N_DEF-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_DEF; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/trig_event_capture_if.sv
// Bundles the event inputs, host controls and trigger/status outputs.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are single-cycle pulses or levels.
interface trig_event_capture_if
    import trig_event_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int HOLD_W = HOLD_W_DEF,
    parameter int MISS_W = MISS_W_DEF
);
    logic [N-1:0]      evt_in;
    logic [N-1:0]      en;
    logic [HOLD_W-1:0] holdoff;
    logic [N-1:0]      ack;
    logic              clr_missed;
    logic [N-1:0]      trig_out;
    logic [N-1:0]      pending;
    logic [N-1:0]      overrun;
    logic [MISS_W-1:0] missed_cnt;
    logic              any_pending;

    // Status/counter logic and host endpoints drive the inputs.
    modport master (
        output evt_in, en, holdoff, ack, clr_missed,
        input  trig_out, pending, overrun, missed_cnt, any_pending
    );

    // The capture block consumes inputs and produces triggers/status.
    modport slave (
        input  evt_in, en, holdoff, ack, clr_missed,
        output trig_out, pending, overrun, missed_cnt, any_pending
    );
endinterface

// File: rtl/trig_event_capture_chan.sv
// One channel: rising-edge detect, holdoff rate limit, sticky pending/overrun.
// Latency: trig_o is high for the single cycle after the edge that saw the rise.
// Backpressure: none; rises inside the holdoff window are dropped and flagged.
module trig_event_chan
    import trig_event_pkg::*;
#(
    parameter int HOLD_W = HOLD_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              evt_i,
    input  logic              en_i,
    input  logic              ack_i,
    input  logic [HOLD_W-1:0] holdoff_i,
    output logic              trig_o,
    output logic              pending_o,
    output logic              overrun_o,
    output logic              drop_o
);
    logic              evt_q, evt_d;
    logic [HOLD_W-1:0] hcnt_q, hcnt_d;
    logic              trig_q, trig_d;
    logic              pend_q, pend_d;
    logic              ovr_q, ovr_d;
    logic              rise, hzero, fire, drop;

    // Edge detect, fire/drop decision and next-state for all channel state.
    always_comb begin
        rise   = evt_i & ~evt_q;
        hzero  = (hcnt_q == '0);
        fire   = rise & en_i & hzero;
        drop   = rise & en_i & ~hzero;
        evt_d  = evt_i;
        trig_d = fire;
        hcnt_d = hcnt_q;
        if (fire) begin
            hcnt_d = holdoff_i;
        end else if (!hzero) begin
            hcnt_d = hcnt_q - HOLD_W'(1);
        end
        // A new fire/drop in the same cycle as an ack keeps the flag set.
        pend_d = fire | (pend_q & ~ack_i);
        ovr_d  = drop | (ovr_q & ~ack_i);
    end

    // Channel registers; evt_q resets high so levels already up at release do not fire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_q  <= 1'b1;
            hcnt_q <= '0;
            trig_q <= 1'b0;
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            evt_q  <= evt_d;
            hcnt_q <= hcnt_d;
            trig_q <= trig_d;
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
        end
    end

    assign trig_o    = trig_q;
    assign pending_o = pend_q;
    assign overrun_o = ovr_q;
    assign drop_o    = drop;
endmodule

// File: rtl/trig_event_capture.sv
// Level events to one-cycle trigger pulses with holdoff, sticky flags and a missed counter.
// Latency: one cycle from rising edge to trig_out; flags and counter update on the same edge.
// Backpressure: none; events arriving during holdoff are dropped and counted (saturating).
module trig_event_capture
    import trig_event_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int HOLD_W = HOLD_W_DEF,
    parameter int MISS_W = MISS_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    trig_event_capture_if.slave  bus
);
    logic [N-1:0]      trig_w, pend_w, ovr_w, drop_w;
    logic [CNT_W-1:0]  drop_cnt;
    logic [MISS_W-1:0] miss_base;
    logic [MISS_W:0]   miss_sum;
    logic [MISS_W-1:0] miss_q, miss_d;

    for (genvar i = 0; i < N; i++) begin : g_chan
        trig_event_chan #(.HOLD_W(HOLD_W)) u_chan (
            .clk       (clk),
            .reset     (reset),
            .evt_i     (bus.evt_in[i]),
            .en_i      (bus.en[i]),
            .ack_i     (bus.ack[i]),
            .holdoff_i (bus.holdoff),
            .trig_o    (trig_w[i]),
            .pending_o (pend_w[i]),
            .overrun_o (ovr_w[i]),
            .drop_o    (drop_w[i])
        );
    end

    // Clear takes effect before this cycle's drops are added; one extra bit catches overflow.
    always_comb begin
        drop_cnt  = popcount(N_DEF'(drop_w));
        miss_base = bus.clr_missed ? '0 : miss_q;
        miss_sum  = {1'b0, miss_base} + (MISS_W + 1)'(drop_cnt);
        miss_d    = miss_sum[MISS_W] ? {MISS_W{1'b1}} : miss_sum[MISS_W-1:0];
    end

    // Missed-event counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miss_q <= '0;
        end else begin
            miss_q <= miss_d;
        end
    end

    assign bus.trig_out    = trig_w;
    assign bus.pending     = pend_w;
    assign bus.overrun     = ovr_w;
    assign bus.missed_cnt  = miss_q;
    assign bus.any_pending = |pend_w;
endmodule

// File: tb/tb_trig_event_capture.sv
// Scoreboard bench for trig_event_capture: stimulus is driven on the falling edge,
// expected outputs are queued with it and compared on the next falling edge.
module tb_trig_event_capture;
    import trig_event_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    trig_event_capture_if #(.N(16), .HOLD_W(8), .MISS_W(16)) bus ();

    trig_event_capture #(.N(16), .HOLD_W(8), .MISS_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef enum int {F_TRIG, F_PEND, F_OVR, F_MISS, F_ANY} fld_e;
    typedef struct {
        string       name;
        fld_e        f;
        logic [15:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic logic [15:0] obs(input fld_e f);
        case (f)
            F_TRIG:  return bus.trig_out;
            F_PEND:  return bus.pending;
            F_OVR:   return bus.overrun;
            F_MISS:  return bus.missed_cnt;
            default: return {15'b0, bus.any_pending};
        endcase
    endfunction

    task automatic push(input string n, input fld_e f, input logic [15:0] v);
        exp_t e;
        e.name = n;
        e.f    = f;
        e.v    = v;
        sb.push_back(e);
    endtask

    // Hold reset, release it with evt_in at the given level, then let evt_q settle one cycle.
    task automatic do_reset(input logic [15:0] evt);
        reset          = 1'b1;
        bus.evt_in     = evt;
        bus.en         = 16'hFFFF;
        bus.ack        = 16'h0000;
        bus.clr_missed = 1'b0;
        bus.holdoff    = 8'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] ev [6] = '{16'h0001, 16'h0001, 16'h0000, 16'h0001, 16'h0001, 16'h0000};
        logic [15:0] et [6] = '{16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000};
        logic [15:0] ep [6] = '{16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h0001};
        exp_t e;
        reset          = 1'b1;
        bus.evt_in     = 16'h0001;
        bus.en         = 16'hFFFF;
        bus.ack        = 16'h0000;
        bus.clr_missed = 1'b0;
        bus.holdoff    = 8'd0;
        push("rst_trig", F_TRIG, 16'h0000);
        push("rst_pend", F_PEND, 16'h0000);
        push("rst_ovr",  F_OVR,  16'h0000);
        push("rst_miss", F_MISS, 16'h0000);
        push("rst_any",  F_ANY,  16'h0000);
        repeat (2) @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_assert++;
            if (obs(e.f) !== e.v) begin
                n_fail++;
                $display("FAIL %s in reset: observed %h, expected %h", e.name, obs(e.f), e.v);
            end
        end
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            bus.evt_in = ev[c];
            push("release_trig", F_TRIG, et[c]);
            push("release_pend", F_PEND, ep[c]);
            push("release_any",  F_ANY,  {15'b0, ep[c][0]});
            push("release_ovr",  F_OVR,  16'h0000);
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_assert++;
                if (obs(e.f) !== e.v) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d: observed %h, expected %h", e.name, c, obs(e.f), e.v);
                end
            end
        end
    endtask

    task automatic test_holdoff();
        logic [7:0] b3 = 8'b0100_0101;  // bit c = level of evt_in[3] in cycle c
        logic [7:0] ft = 8'b0100_0001;  // trig expected after cycle c
        exp_t e;
        do_reset(16'h0000);
        bus.holdoff = 8'd4;
        for (int c = 0; c < 8; c++) begin
            bus.evt_in = b3[c] ? 16'h0008 : 16'h0000;
            push("hold_trig", F_TRIG, ft[c] ? 16'h0008 : 16'h0000);
            push("hold_pend", F_PEND, 16'h0008);
            push("hold_ovr",  F_OVR,  (c >= 2) ? 16'h0008 : 16'h0000);
            push("hold_miss", F_MISS, (c >= 2) ? 16'd1 : 16'd0);
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_assert++;
                if (obs(e.f) !== e.v) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d: observed %h, expected %h", e.name, c, obs(e.f), e.v);
                end
            end
        end
    endtask

    task automatic test_enable();
        logic [15:0] ev [3] = '{16'h0003, 16'h0000, 16'h0001};
        logic [15:0] et [3] = '{16'h0002, 16'h0000, 16'h0000};
        exp_t e;
        do_reset(16'h0000);
        bus.en = 16'hFFFE;
        for (int c = 0; c < 3; c++) begin
            bus.evt_in = ev[c];
            push("en_trig", F_TRIG, et[c]);
            push("en_pend", F_PEND, 16'h0002);
            push("en_miss", F_MISS, 16'd0);
            push("en_ovr",  F_OVR,  16'h0000);
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_assert++;
                if (obs(e.f) !== e.v) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d: observed %h, expected %h", e.name, c, obs(e.f), e.v);
                end
            end
        end
    endtask

    task automatic test_ack();
        logic [7:0]  b1 = 8'b0101_0101;
        logic [7:0]  ak = 8'b1101_0000;
        logic [15:0] et [8] = '{16'h2, 16'h0, 16'h0, 16'h0, 16'h2, 16'h0, 16'h0, 16'h0};
        logic [15:0] ep [8] = '{16'h2, 16'h2, 16'h2, 16'h2, 16'h2, 16'h2, 16'h0, 16'h0};
        logic [15:0] eo [8] = '{16'h0, 16'h0, 16'h2, 16'h2, 16'h0, 16'h0, 16'h2, 16'h0};
        logic [15:0] em [8] = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd2, 16'd2};
        exp_t e;
        do_reset(16'h0000);
        bus.holdoff = 8'd2;
        for (int c = 0; c < 8; c++) begin
            bus.evt_in = b1[c] ? 16'h0002 : 16'h0000;
            bus.ack    = ak[c] ? 16'h0002 : 16'h0000;
            push("ack_trig", F_TRIG, et[c]);
            push("ack_pend", F_PEND, ep[c]);
            push("ack_ovr",  F_OVR,  eo[c]);
            push("ack_miss", F_MISS, em[c]);
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_assert++;
                if (obs(e.f) !== e.v) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d: observed %h, expected %h", e.name, c, obs(e.f), e.v);
                end
            end
        end
        bus.ack = 16'h0000;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        do_reset(16'h0000);
        for (int c = 0; c < 6; c++) begin
            bus.evt_in = (c % 2 == 0) ? 16'h0080 : 16'h0000;
            push("b2b_trig", F_TRIG, (c % 2 == 0) ? 16'h0080 : 16'h0000);
            push("b2b_miss", F_MISS, 16'd0);
            push("b2b_ovr",  F_OVR,  16'h0000);
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_assert++;
                if (obs(e.f) !== e.v) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d: observed %h, expected %h", e.name, c, obs(e.f), e.v);
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] em [5] = '{16'd0, 16'd0, 16'd16, 16'd16, 16'd32};
        exp_t e;
        do_reset(16'h0000);
        bus.holdoff = 8'd255;
        for (int c = 0; c < 5 + 10004; c++) begin
            bus.evt_in = (c % 2 == 0) ? 16'hFFFF : 16'h0000;
            if (c < 5) begin
                push("sat_trig", F_TRIG, (c == 0) ? 16'hFFFF : 16'h0000);
                push("sat_miss", F_MISS, em[c]);
                push("sat_ovr",  F_OVR,  (c >= 2) ? 16'hFFFF : 16'h0000);
            end else if (c == 5 + 10000 || c == 5 + 10003) begin
                push("sat_hold", F_MISS, MISS_MAX);
            end
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_assert++;
                if (obs(e.f) !== e.v) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d: observed %h, expected %h", e.name, c, obs(e.f), e.v);
                end
            end
        end
    endtask

    task automatic test_clear_and_reset();
        logic [15:0] ev [8] = '{16'h7, 16'h0, 16'h7, 16'h0, 16'h7, 16'h0, 16'h0, 16'h20};
        logic [7:0]  cl = 8'b0101_0000;
        logic [15:0] et [8] = '{16'h7, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h20};
        logic [15:0] ep [8] = '{16'h7, 16'h7, 16'h7, 16'h7, 16'h7, 16'h7, 16'h7, 16'h27};
        logic [15:0] em [8] = '{16'd0, 16'd0, 16'd3, 16'd3, 16'd3, 16'd3, 16'd0, 16'd0};
        exp_t e;
        do_reset(16'h0000);
        bus.holdoff = 8'd255;
        for (int c = 0; c < 8; c++) begin
            bus.evt_in     = ev[c];
            bus.clr_missed = cl[c];
            push("clr_trig", F_TRIG, et[c]);
            push("clr_pend", F_PEND, ep[c]);
            push("clr_miss", F_MISS, em[c]);
            push("clr_ovr",  F_OVR,  (c >= 2) ? 16'h0007 : 16'h0000);
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_assert++;
                if (obs(e.f) !== e.v) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d: observed %h, expected %h", e.name, c, obs(e.f), e.v);
                end
            end
        end
        bus.clr_missed = 1'b0;
        // trig_out[5] is high right now; reset must cut it off immediately.
        reset = 1'b1;
        push("midrst_trig", F_TRIG, 16'h0000);
        push("midrst_pend", F_PEND, 16'h0000);
        push("midrst_ovr",  F_OVR,  16'h0000);
        push("midrst_miss", F_MISS, 16'h0000);
        push("midrst_any",  F_ANY,  16'h0000);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_assert++;
            if (obs(e.f) !== e.v) begin
                n_fail++;
                $display("FAIL %s after reset: observed %h, expected %h", e.name, obs(e.f), e.v);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            push("postrst_trig", F_TRIG, 16'h0000);
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_assert++;
                if (obs(e.f) !== e.v) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d: observed %h, expected %h", e.name, c, obs(e.f), e.v);
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_holdoff();
        test_enable();
        test_ack();
        test_back_to_back();
        test_saturation();
        test_clear_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
